// File: rtl/dcsk_tx_mc.sv
// dcsk_tx_mc: serial DCSK / CSK chaos-shift-keying transmitter.
// A Galois LFSR provides the chaotic chip stream. In DCSK mode each message
// bit is sent as SF reference chips followed by SF data chips, where the data
// chips are the stored reference XNOR the bit. In CSK mode each bit is sent as
// SF chips of LFSR output XNOR the bit.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_seed, i_load_seed      LFSR seed and load strobe (honoured in idle only)
//   i_sf, i_mode, i_msg      spreading factor, mode (0 DCSK, 1 CSK), message
//   i_msg_valid/o_msg_ready  message handshake
//   i_abort                  abort the frame in flight
//   o_tx, o_tx_valid         registered serial chip and its valid
//   o_is_ref                 current chip is a DCSK reference chip
//   o_bit_idx                index of the message bit being sent
//   o_sf_err                 one-cycle pulse after accepting an invalid SF
module dcsk_tx_mc #(
   parameter int unsigned       MSG_W  = 32,
   parameter int unsigned       SF_MAX = 64,
   parameter int unsigned       SEED_W = 16,
   parameter logic [SEED_W-1:0] TAPS   = 16'hB400
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [SEED_W-1:0]            i_seed,
   input  logic                         i_load_seed,
   input  logic [$clog2(SF_MAX+1)-1:0]  i_sf,
   input  logic                         i_mode,
   input  logic [MSG_W-1:0]             i_msg,
   input  logic                         i_msg_valid,
   output logic                         o_msg_ready,
   input  logic                         i_abort,
   output logic                         o_tx,
   output logic                         o_tx_valid,
   output logic                         o_is_ref,
   output logic [$clog2(MSG_W)-1:0]     o_bit_idx,
   output logic                         o_sf_err
);

   localparam int unsigned SF_W  = $clog2(SF_MAX + 1);
   localparam int unsigned CNT_W = $clog2(SF_MAX);
   localparam int unsigned BIT_W = $clog2(MSG_W);

   typedef enum logic [1:0] {S_IDLE, S_REF, S_DATA} state_t;

   state_t              r_state, w_state_nxt;
   logic [SEED_W-1:0]   r_lfsr, w_lfsr_nxt, w_lfsr_adv;
   logic [CNT_W-1:0]    r_chip, w_chip_nxt, w_chip_inc, r_sf_m1;
   logic [BIT_W-1:0]    r_bit, w_bit_nxt, w_bit_inc;
   logic [MSG_W-1:0]    r_msg;
   logic                r_mode;
   logic [SF_MAX-1:0]   r_buf;
   logic                r_tx, r_valid, r_is_ref, r_sf_err;
   logic                w_tx_nxt, w_valid_nxt, w_is_ref_nxt, w_sf_err_nxt;
   logic                w_accept, w_buf_we;
   logic [CNT_W-1:0]    w_buf_addr;
   logic                w_sf_ok, w_last_chip, w_last_bit, w_cur_bit, w_nxt_bit;

   // Helper terms for the next-state logic
   assign w_lfsr_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
   assign w_sf_ok     = (i_sf >= SF_W'(2)) && (i_sf <= SF_W'(SF_MAX));
   assign w_chip_inc  = r_chip + CNT_W'(1);
   assign w_bit_inc   = r_bit + BIT_W'(1);
   assign w_last_chip = (r_chip == r_sf_m1);
   assign w_last_bit  = (r_bit == BIT_W'(MSG_W - 1));
   assign w_cur_bit   = r_msg[r_bit];
   assign w_nxt_bit   = r_msg[w_bit_inc];

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, next chip and datapath controls; the chip computed here is
   // the one presented on o_tx in the following cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_lfsr_nxt   = r_lfsr;
      w_chip_nxt   = r_chip;
      w_bit_nxt    = r_bit;
      w_tx_nxt     = 1'b0;
      w_valid_nxt  = 1'b0;
      w_is_ref_nxt = 1'b0;
      w_sf_err_nxt = 1'b0;
      w_accept     = 1'b0;
      w_buf_we     = 1'b0;
      w_buf_addr   = '0;
      case (r_state)
         S_IDLE: begin
            if (i_load_seed) begin
               w_lfsr_nxt = (i_seed == '0) ? SEED_W'(1) : i_seed;
            end else if (i_msg_valid) begin
               if (w_sf_ok) begin
                  w_accept    = 1'b1;
                  w_chip_nxt  = '0;
                  w_bit_nxt   = '0;
                  w_lfsr_nxt  = w_lfsr_adv;
                  w_valid_nxt = 1'b1;
                  if (!i_mode) begin
                     w_state_nxt  = S_REF;
                     w_tx_nxt     = r_lfsr[0];
                     w_is_ref_nxt = 1'b1;
                     w_buf_we     = 1'b1;
                  end else begin
                     w_state_nxt = S_DATA;
                     w_tx_nxt    = r_lfsr[0] ~^ i_msg[0];
                  end
               end else begin
                  w_sf_err_nxt = 1'b1;
               end
            end
         end
         S_REF: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (!w_last_chip) begin
               w_chip_nxt   = w_chip_inc;
               w_tx_nxt     = r_lfsr[0];
               w_is_ref_nxt = 1'b1;
               w_valid_nxt  = 1'b1;
               w_buf_we     = 1'b1;
               w_buf_addr   = w_chip_inc;
               w_lfsr_nxt   = w_lfsr_adv;
            end else begin
               w_state_nxt = S_DATA;
               w_chip_nxt  = '0;
               w_tx_nxt    = r_buf[0] ~^ w_cur_bit;
               w_valid_nxt = 1'b1;
            end
         end
         S_DATA: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (!w_last_chip) begin
               w_chip_nxt  = w_chip_inc;
               w_valid_nxt = 1'b1;
               if (r_mode) begin
                  w_tx_nxt   = r_lfsr[0] ~^ w_cur_bit;
                  w_lfsr_nxt = w_lfsr_adv;
               end else begin
                  w_tx_nxt = r_buf[w_chip_inc] ~^ w_cur_bit;
               end
            end else if (!w_last_bit) begin
               w_bit_nxt   = w_bit_inc;
               w_chip_nxt  = '0;
               w_valid_nxt = 1'b1;
               w_lfsr_nxt  = w_lfsr_adv;
               if (r_mode) begin
                  w_tx_nxt = r_lfsr[0] ~^ w_nxt_bit;
               end else begin
                  w_state_nxt  = S_REF;
                  w_tx_nxt     = r_lfsr[0];
                  w_is_ref_nxt = 1'b1;
                  w_buf_we     = 1'b1;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr   <= SEED_W'(1);
         r_chip   <= '0;
         r_bit    <= '0;
         r_sf_m1  <= '0;
         r_msg    <= '0;
         r_mode   <= 1'b0;
         r_tx     <= 1'b0;
         r_valid  <= 1'b0;
         r_is_ref <= 1'b0;
         r_sf_err <= 1'b0;
      end else begin
         r_lfsr   <= w_lfsr_nxt;
         r_chip   <= w_chip_nxt;
         r_bit    <= w_bit_nxt;
         r_tx     <= w_tx_nxt;
         r_valid  <= w_valid_nxt;
         r_is_ref <= w_is_ref_nxt;
         r_sf_err <= w_sf_err_nxt;
         if (w_accept) begin
            r_sf_m1 <= CNT_W'(i_sf - SF_W'(1));
            r_msg   <= i_msg;
            r_mode  <= i_mode;
         end
      end
   end

   // Reference chip buffer; contents are only read after being written
   always_ff @(posedge i_clk) begin
      if (w_buf_we) r_buf[w_buf_addr] <= r_lfsr[0];
   end

   assign o_msg_ready = (r_state == S_IDLE) && !i_load_seed;
   assign o_tx        = r_tx;
   assign o_tx_valid  = r_valid;
   assign o_is_ref    = r_is_ref;
   assign o_bit_idx   = r_bit;
   assign o_sf_err    = r_sf_err;

endmodule

// File: tb/tb_dcsk_tx_mc.sv
// Self-checking bench for dcsk_tx_mc with a frame-level reference model.
module tb_dcsk_tx_mc;

   localparam int MSG_W  = 8;
   localparam int SF_MAX = 16;
   localparam int SEED_W = 16;
   localparam int SF_W   = $clog2(SF_MAX + 1);
   localparam int BIT_W  = $clog2(MSG_W);
   localparam logic [15:0] TAPS = 16'hB400;

   logic              clk = 1'b0;
   logic              i_rst = 1'b1;
   logic [15:0]       i_seed = '0;
   logic              i_load_seed = 1'b0;
   logic [SF_W-1:0]   i_sf = '0;
   logic              i_mode = 1'b0;
   logic [MSG_W-1:0]  i_msg = '0;
   logic              i_msg_valid = 1'b0;
   logic              i_abort = 1'b0;
   logic              o_msg_ready, o_tx, o_tx_valid, o_is_ref, o_sf_err;
   logic [BIT_W-1:0]  o_bit_idx;

   always #5 clk = ~clk;

   dcsk_tx_mc #(.MSG_W(MSG_W), .SF_MAX(SF_MAX), .SEED_W(SEED_W), .TAPS(TAPS)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_seed(i_seed), .i_load_seed(i_load_seed),
      .i_sf(i_sf), .i_mode(i_mode), .i_msg(i_msg), .i_msg_valid(i_msg_valid),
      .o_msg_ready(o_msg_ready), .i_abort(i_abort), .o_tx(o_tx),
      .o_tx_valid(o_tx_valid), .o_is_ref(o_is_ref), .o_bit_idx(o_bit_idx),
      .o_sf_err(o_sf_err));

   typedef struct {
      bit          tx;
      bit          is_ref;
      int          bidx;
      logic [15:0] lf;    // LFSR state once this chip has been produced
   } chip_t;
   typedef chip_t chip_q_t[$];

   // Model state
   chip_q_t     q;
   chip_t       cur;
   bit          m_busy = 0;
   bit          exp_err = 0;
   logic [15:0] m_lfsr = 16'h0001;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 0;
   bit cap_tx[$];
   bit cap_ref[$];
   int cap_bidx[$];

   function automatic logic [15:0] adv(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
   endfunction

   // Whole-frame chip list derived from the modulation rules
   function automatic chip_q_t build(input logic [15:0] lf0, input logic [MSG_W-1:0] msg,
                                     input int sf, input bit csk);
      chip_q_t     r;
      bit          refs[$];
      logic [15:0] lf = lf0;
      for (int b = 0; b < MSG_W; b++) begin
         if (!csk) begin
            refs.delete();
            for (int k = 0; k < sf; k++) begin
               refs.push_back(lf[0]);
               lf = adv(lf);
               r.push_back('{tx: refs[k], is_ref: 1'b1, bidx: b, lf: lf});
            end
            for (int k = 0; k < sf; k++)
               r.push_back('{tx: ~(refs[k] ^ msg[b]), is_ref: 1'b0, bidx: b, lf: lf});
         end else begin
            for (int k = 0; k < sf; k++) begin
               bit t = lf[0] ~^ msg[b];
               lf = adv(lf);
               r.push_back('{tx: t, is_ref: 1'b0, bidx: b, lf: lf});
            end
         end
      end
      return r;
   endfunction

   // Reference model: decides what the outputs must show after each edge
   always @(posedge clk) begin
      exp_err = 0;
      if (i_rst) begin
         q.delete();
         m_busy = 0;
         m_lfsr = 16'h0001;
      end else if (m_busy) begin
         if (i_abort || q.size() == 0) begin
            m_lfsr = cur.lf;
            m_busy = 0;
         end else begin
            cur = q.pop_front();
         end
      end else if (i_load_seed) begin
         m_lfsr = (i_seed == 16'h0) ? 16'h0001 : i_seed;
      end else if (i_msg_valid) begin
         if (int'(i_sf) >= 2 && int'(i_sf) <= SF_MAX) begin
            q = build(m_lfsr, i_msg, int'(i_sf), i_mode);
            cur = q.pop_front();
            m_busy = 1;
         end else begin
            exp_err = 1;
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle
   task automatic compare_cycle();
      bit exp_rdy, exp_tx, ok;
      exp_rdy = !m_busy && !i_load_seed;
      exp_tx  = m_busy ? cur.tx : 1'b0;
      ok = (o_tx_valid == m_busy) && (o_tx == exp_tx) && (o_sf_err == exp_err) &&
           (o_msg_ready == exp_rdy) &&
           (!m_busy || (o_is_ref == cur.is_ref && int'(o_bit_idx) == cur.bidx));
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL cycle t=%0t got vld=%b tx=%b ref=%b bit=%0d err=%b rdy=%b want vld=%b tx=%b ref=%b bit=%0d err=%b rdy=%b",
                  $time, o_tx_valid, o_tx, o_is_ref, o_bit_idx, o_sf_err, o_msg_ready,
                  m_busy, exp_tx, cur.is_ref, cur.bidx, exp_err, exp_rdy);
      end
      if (o_tx_valid) begin
         cap_tx.push_back(o_tx);
         cap_ref.push_back(o_is_ref);
         cap_bidx.push_back(int'(o_bit_idx));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      cap_tx.delete();
      cap_ref.delete();
      cap_bidx.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (m_busy && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", int'(m_busy), 0);
   endtask

   task automatic load_seed(input logic [15:0] s);
      i_seed = s;
      i_load_seed = 1;
      tick();
      i_load_seed = 0;
   endtask

   // One accept, then scramble the inputs to show the frame ignores them
   task automatic send(input logic [MSG_W-1:0] msg, input int sf, input bit csk);
      i_msg = msg;
      i_sf = SF_W'(sf);
      i_mode = csk;
      i_msg_valid = 1;
      tick();
      i_msg_valid = 0;
      i_msg = MSG_W'($urandom);
      i_sf = SF_W'($urandom);
      i_mode = 1'($urandom);
      wait_idle(2000);
   endtask

   initial begin
      chip_q_t     pq;
      logic [15:0] lit_tx, lit_ref;
      int          phase, gap;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) compare_cycle();
         end
      join_none

      // Pin the model with hand-derived sequences
      lit_tx  = 16'b1000_0111_0000_0000;
      lit_ref = 16'b1111_0000_1111_0000;
      pq = build(16'h0001, 8'h02, 4, 0);
      check("pin_dcsk_len", pq.size(), MSG_W * 8);
      for (int i = 0; i < 16; i++) begin
         check("pin_dcsk_tx", int'(pq[i].tx), int'(lit_tx[15-i]));
         check("pin_dcsk_ref", int'(pq[i].is_ref), int'(lit_ref[15-i]));
         check("pin_dcsk_bit", pq[i].bidx, (i < 8) ? 0 : 1);
      end
      pq = build(16'h0001, 8'h01, 4, 1);
      check("pin_csk_len", pq.size(), MSG_W * 4);
      for (int i = 0; i < 4; i++) begin
         check("pin_csk_tx", int'(pq[i].tx), (i == 0) ? 1 : 0);
         check("pin_csk_ref", int'(pq[i].is_ref), 0);
      end

      // Reset state
      tick();
      chk_en = 1;
      tick();
      check("rst_valid", int'(o_tx_valid), 0);
      check("rst_tx", int'(o_tx), 0);
      check("rst_is_ref", int'(o_is_ref), 0);
      check("rst_bit_idx", int'(o_bit_idx), 0);
      check("rst_sf_err", int'(o_sf_err), 0);
      i_rst = 0;
      #1;
      check("rst_ready", int'(o_msg_ready), 1);

      // DCSK reference frame
      load_seed(16'h0001);
      clear_cap();
      send(8'h02, 4, 0);
      check("dcsk_len", cap_tx.size(), MSG_W * 8);
      for (int i = 0; i < 16 && i < cap_tx.size(); i++) begin
         check("dcsk_tx", int'(cap_tx[i]), int'(lit_tx[15-i]));
         check("dcsk_ref", int'(cap_ref[i]), int'(lit_ref[15-i]));
         check("dcsk_bit", cap_bidx[i], (i < 8) ? 0 : 1);
      end

      // CSK frame after a zero seed load (acts as seed 1)
      load_seed(16'h0000);
      clear_cap();
      send(8'h01, 4, 1);
      check("csk_len", cap_tx.size(), MSG_W * 4);
      for (int i = 0; i < 4 && i < cap_tx.size(); i++)
         check("csk_tx", int'(cap_tx[i]), (i == 0) ? 1 : 0);

      // Invalid spreading factors
      clear_cap();
      for (int s = 0; s < 3; s++) begin
         i_sf = (s == 0) ? SF_W'(1) : ((s == 1) ? SF_W'(SF_MAX + 1) : SF_W'(0));
         i_msg_valid = 1;
         tick();
         i_msg_valid = 0;
         check("sf_err_pulse", int'(o_sf_err), 1);
         tick();
         check("sf_err_clear", int'(o_sf_err), 0);
      end
      check("sf_err_no_chips", cap_tx.size(), 0);

      // Maximum spreading factor
      load_seed(16'h0001);
      clear_cap();
      send(MSG_W'($urandom), SF_MAX, 0);
      check("sfmax_len", cap_tx.size(), MSG_W * 2 * SF_MAX);
      if (cap_ref.size() > SF_MAX) begin
         check("sfmax_last_ref", int'(cap_ref[SF_MAX-1]), 1);
         check("sfmax_first_data", int'(cap_ref[SF_MAX]), 0);
      end

      // Back-to-back frames with valid held
      i_sf = SF_W'(3);
      i_mode = 0;
      i_msg_valid = 1;
      phase = 0;
      gap = 0;
      for (int c = 0; c < 110; c++) begin
         i_msg = MSG_W'($urandom);
         tick();
         case (phase)
            0: if (o_tx_valid) phase = 1;
            1: if (!o_tx_valid) begin phase = 2; gap = 1; end
            2: if (!o_tx_valid) gap++; else phase = 3;
            default: ;
         endcase
      end
      i_msg_valid = 0;
      check("b2b_second_frame", phase, 3);
      check("b2b_gap", gap, 1);
      wait_idle(2000);

      // Abort on the third chip, then continue the LFSR sequence
      load_seed(16'h0001);
      clear_cap();
      i_msg = 8'h55;
      i_sf = SF_W'(4);
      i_mode = 0;
      i_msg_valid = 1;
      tick();
      i_msg_valid = 0;
      tick();
      tick();
      i_abort = 1;
      tick();
      i_abort = 0;
      check("abort_valid", int'(o_tx_valid), 0);
      check("abort_ready", int'(o_msg_ready), 1);
      check("abort_chips", cap_tx.size(), 3);
      clear_cap();
      send(8'h00, 4, 0);
      for (int i = 0; i < 4 && i < cap_tx.size(); i++)
         check("abort_resume_tx", int'(cap_tx[i]), 0);

      // Seed load while busy is ignored
      load_seed(16'h0001);
      i_msg = 8'hA5;
      i_sf = SF_W'(5);
      i_mode = 1;
      i_msg_valid = 1;
      tick();
      i_msg_valid = 0;
      repeat (5) tick();
      i_seed = 16'hFFFF;
      i_load_seed = 1;
      tick();
      i_load_seed = 0;
      wait_idle(2000);

      // Reset in the middle of a frame
      i_msg = 8'h3C;
      i_sf = SF_W'(4);
      i_mode = 0;
      i_msg_valid = 1;
      tick();
      i_msg_valid = 0;
      repeat (5) tick();
      i_rst = 1;
      tick();
      i_rst = 0;
      check("rst_mid_valid", int'(o_tx_valid), 0);
      tick();
      check("rst_mid_after", int'(o_tx_valid), 0);

      // Randomized traffic
      for (int c = 0; c < 5000; c++) begin
         int r = $urandom_range(0, 99);
         i_msg = MSG_W'($urandom);
         if (r < 3)       i_sf = SF_W'(SF_MAX);
         else if (r < 8)  i_sf = SF_W'($urandom_range(0, 1));
         else if (r < 10) i_sf = SF_W'(SF_MAX + 1);
         else             i_sf = SF_W'($urandom_range(2, 5));
         i_mode = 1'($urandom);
         i_msg_valid = ($urandom_range(0, 2) != 0);
         i_load_seed = ($urandom_range(0, 15) == 0);
         i_seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         i_abort = ($urandom_range(0, 63) == 0);
         i_rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      i_msg_valid = 0;
      i_load_seed = 0;
      i_abort = 0;
      i_rst = 0;
      wait_idle(2000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
